// File: rtl/calc_pkg.sv
// Shared calculator output-stage definitions: FSM encoding, BCD adjust constants,
// and the seven-segment lookup table (bit 0 = segment a ... bit 6 = segment g).
package calc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ        = 4'd3;

   // Indexed by BCD digit value; entries 10-15 are blank.
   localparam logic [15:0][6:0] SEG7 = {
      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/bcd_dabble_cell.sv
// Double-dabble digit correction: digit+3 when digit >= 5, otherwise unchanged.
// Latency: combinational. Backpressure: none.
// Used once per BCD digit ahead of each shift.
module bcd_dabble_cell
   import calc_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adj
);

   assign adj = (digit >= BCD_ADJ_THRESH) ? (digit + BCD_ADJ) : digit;

endmodule

// File: rtl/result_bcd_decoder.sv
// Sequential sign/magnitude binary-to-BCD decoder for the calculator result bus.
// Latency: start accepted at edge N -> done pulse after edge N+WIDTH+1, data-independent.
// Backpressure: start ignored while busy and in DONE; no queueing. RESULT_SEG7_EN adds seg/seg_minus.
module result_bcd_decoder
   import calc_pkg::*;
#(
   parameter int WIDTH  = 10,
   parameter int DIGITS = 3
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WIDTH:0]      data_in,
   output logic                busy,
   output logic                done,
   output logic                sign,
   output logic                ovf,
   output logic [DIGITS*4-1:0] bcd
`ifdef RESULT_SEG7_EN
   ,
   output logic [DIGITS*7-1:0] seg,
   output logic                seg_minus
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = DIGITS * 4;

   state_t           state_q;
   state_t           state_d;
   logic             accept;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] mag_q;
   logic [BW-1:0]    scratch_q;
   logic [BW-1:0]    scratch_adj;
   logic             sign_cap_q;
   logic             ovf_cap_q;
   logic [WIDTH-1:0] value;
   logic [WIDTH-1:0] value_abs;
   logic [BW-1:0]    bcd_next;
   logic             sign_next;

   // Magnitude fits WIDTH bits unsigned, so the most negative value converts without loss.
   assign value     = data_in[WIDTH-1:0];
   assign value_abs = value[WIDTH-1] ? ((~value) + WIDTH'(1)) : value;

   // An overflowed result is presented as an unsigned zero.
   assign bcd_next  = ovf_cap_q ? '0 : scratch_q;
   assign sign_next = sign_cap_q & ~ovf_cap_q;

   for (genvar g = 0; g < DIGITS; g++) begin : g_cell
      bcd_dabble_cell u_cell (
         .digit (scratch_q[g*4 +: 4]),
         .adj   (scratch_adj[g*4 +: 4])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      busy    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            busy = 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            busy    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         mag_q      <= '0;
         scratch_q  <= '0;
         sign_cap_q <= 1'b0;
         ovf_cap_q  <= 1'b0;
         done       <= 1'b0;
         sign       <= 1'b0;
         ovf        <= 1'b0;
         bcd        <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            ovf_cap_q  <= data_in[WIDTH];
            sign_cap_q <= data_in[WIDTH-1];
            mag_q      <= value_abs;
            scratch_q  <= '0;
            cnt_q      <= CW'(WIDTH);
         end else if (state_q == ST_SHIFT) begin
            scratch_q <= {scratch_adj[BW-2:0], mag_q[WIDTH-1]};
            mag_q     <= {mag_q[WIDTH-2:0], 1'b0};
            cnt_q     <= cnt_q - CW'(1);
         end else if (state_q == ST_DONE) begin
            done <= 1'b1;
            ovf  <= ovf_cap_q;
            sign <= sign_next;
            bcd  <= bcd_next;
         end
      end
   end

`ifdef RESULT_SEG7_EN
   logic [DIGITS*7-1:0] seg_next;
   logic                lead_zero;

   // Blank zero digits from the top down until the first non-zero; units always shown.
   always_comb begin
      seg_next  = '0;
      lead_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (lead_zero && (bcd_next[i*4 +: 4] == 4'd0) && (i != 0)) begin
            seg_next[i*7 +: 7] = 7'b0;
         end else begin
            lead_zero          = 1'b0;
            seg_next[i*7 +: 7] = SEG7[bcd_next[i*4 +: 4]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg       <= '0;
         seg_minus <= 1'b0;
      end else if (state_q == ST_DONE) begin
         seg       <= seg_next;
         seg_minus <= sign_next;
      end
   end
`endif

endmodule

// File: tb/tb_result_bcd_decoder.sv
// Directed self-checking bench for result_bcd_decoder: latency, values, busy/start
// interaction, mid-conversion reset, and segment output when RESULT_SEG7_EN is defined.
module tb_result_bcd_decoder;

   localparam int WIDTH  = 10;
   localparam int DIGITS = 3;

   logic                clk;
   logic                rst;
   logic                start;
   logic [WIDTH:0]      data_in;
   logic                busy;
   logic                done;
   logic                sign;
   logic                ovf;
   logic [DIGITS*4-1:0] bcd;
`ifdef RESULT_SEG7_EN
   logic [DIGITS*7-1:0] seg;
   logic                seg_minus;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   result_bcd_decoder #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .data_in   (data_in),
      .busy      (busy),
      .done      (done),
      .sign      (sign),
      .ovf       (ovf),
      .bcd       (bcd)
`ifdef RESULT_SEG7_EN
      ,
      .seg       (seg),
      .seg_minus (seg_minus)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where done is high.
   task automatic run_conv(input logic [WIDTH:0] d, input logic [11:0] exp_bcd,
                           input logic exp_sign, input logic exp_ovf);
      int k;
      int nb;
      start   = 1'b1;
      data_in = d;
      @(negedge clk);
      start   = 1'b0;
      data_in = 11'h7FF;
      k  = 0;
      nb = 0;
      while (!done && k < 40) begin
         if (busy) nb++;
         k++;
         @(negedge clk);
      end
      check_eq("latency", k, WIDTH + 1);
      check_eq("busy_len", nb, WIDTH + 1);
      check_eq("bcd", bcd, exp_bcd);
      check_eq("sign", sign, exp_sign);
      check_eq("ovf", ovf, exp_ovf);
   endtask

   initial begin
      int ndone;
      int dk;
      int busy_late;
      int seen;
      logic [11:0] got_bcd;

      rst     = 1'b1;
      start   = 1'b0;
      data_in = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_bcd", bcd, 12'h000);
      check_eq("rst_sign_ovf", {sign, ovf}, 2'b00);
`ifdef RESULT_SEG7_EN
      check_eq("rst_seg", {seg_minus, seg}, 22'h0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back conversions: each starts in the done cycle of the previous one.
      run_conv(11'h000, 12'h000, 1'b0, 1'b0);
      run_conv(11'h1FF, 12'h511, 1'b0, 1'b0);
      run_conv(11'h200, 12'h512, 1'b1, 1'b0);
      run_conv(11'h3FF, 12'h001, 1'b1, 1'b0);
      run_conv(11'h5F6, 12'h000, 1'b0, 1'b1);

      @(negedge clk);
      check_eq("done_pulse_1cyc", done, 1'b0);
      check_eq("hold_ovf", ovf, 1'b1);

      // start during SHIFT and during DONE must be ignored.
      start   = 1'b1;
      data_in = 11'h07B;
      @(negedge clk);
      start     = 1'b0;
      data_in   = 11'h1FF;
      ndone     = 0;
      dk        = -1;
      busy_late = 0;
      got_bcd   = '0;
      for (int k = 0; k < 20; k++) begin
         if (done) begin
            ndone++;
            dk      = k;
            got_bcd = bcd;
         end
         if (k > WIDTH + 1 && busy) busy_late = 1;
         start = (k == 3) || (k == WIDTH);
         @(negedge clk);
      end
      start = 1'b0;
      check_eq("ign_ndone", ndone, 1);
      check_eq("ign_latency", dk, WIDTH + 1);
      check_eq("ign_bcd", got_bcd, 12'h123);
      check_eq("ign_no_restart", busy_late, 0);
      check_eq("ign_hold_bcd", bcd, 12'h123);

`ifdef RESULT_SEG7_EN
      run_conv(11'h009, 12'h009, 1'b0, 1'b0);
      check_eq("seg_9", seg, {7'h00, 7'h00, 7'h6F});
      check_eq("seg_minus_9", seg_minus, 1'b0);
      run_conv(11'h3F6, 12'h010, 1'b1, 1'b0);
      check_eq("seg_m10", seg, {7'h00, 7'h06, 7'h3F});
      check_eq("seg_minus_m10", seg_minus, 1'b1);
`endif

      // Reset during the fourth SHIFT cycle after a negative result is on the outputs.
      run_conv(11'h3FF, 12'h001, 1'b1, 1'b0);
      start   = 1'b1;
      data_in = 11'h064;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_busy", busy, 1'b0);
      check_eq("mid_rst_bcd", bcd, 12'h000);
      check_eq("mid_rst_sign_done", {sign, done}, 2'b00);
`ifdef RESULT_SEG7_EN
      check_eq("mid_rst_seg", {seg_minus, seg}, 22'h0);
`endif
      rst  = 1'b0;
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done || busy) seen = 1;
      end
      check_eq("mid_rst_no_done", seen, 0);
      run_conv(11'h00A, 12'h010, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
